// File: rtl/stereo_sequencer.sv
// stereo_sequencer: granule-level controller for the MP3 stereo-processing stage.
//
// On an accepted start it latches the granule side info, streams SAMPLES
// (ch1, ch2, is_pos) triples from the requantizer buffers into the stereo unit
// and writes the stereo results back in order. At most MAX_INFLIGHT pairs are
// outstanding between read issue and stereo dout_v; done pulses for one cycle
// after the final write-back.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   start, gr_in, cfg_*      granule start pulse, granule index and side info
//   rd_en, rd_addr           read strobe/address to the sample and is_pos buffers
//   rd_ch1/rd_ch2/rd_is_pos  buffer data, valid RD_LATENCY cycles after rd_en
//   st_cfg_*, st_gr          latched side info to stereo (stable start..done)
//   st_ch1/st_ch2/st_is_pos  registered pair to stereo, qualified by st_din_v
//   st_dout_v, st_ch*_out    stereo results
//   wr_en, wr_addr, wr_ch*   write-back port to the output buffer
//   busy, done, err          status: RUN/DRAIN, end-of-granule pulse, sticky error
module stereo_sequencer #(
  parameter int unsigned SAMPLES      = 576,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gr_in,
  input  logic [1:0]        cfg_mode,
  input  logic [1:0]        cfg_mode_ext,
  input  logic [8:0]        cfg_big_values,
  input  logic              cfg_wsf,
  input  logic [1:0]        cfg_block_type,
  input  logic              cfg_mixed,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_ch1,
  input  logic [15:0]       rd_ch2,
  input  logic [9:0]        rd_is_pos,
  output logic [1:0]        st_cfg_mode,
  output logic [1:0]        st_cfg_mode_ext,
  output logic [8:0]        st_cfg_big_values,
  output logic              st_cfg_wsf,
  output logic [1:0]        st_cfg_block_type,
  output logic              st_cfg_mixed,
  output logic              st_gr,
  output logic [15:0]       st_ch1,
  output logic [15:0]       st_ch2,
  output logic [9:0]        st_is_pos,
  output logic              st_din_v,
  input  logic              st_dout_v,
  input  logic [15:0]       st_ch1_out,
  input  logic [15:0]       st_ch2_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_ch1,
  output logic [15:0]       wr_ch2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so the counters can hold SAMPLES itself even when SAMPLES == 2**ADDR_W.
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] SamplesC = CntW'(SAMPLES);
  localparam logic [3:0] MaxInflC = 4'(MAX_INFLIGHT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]       out_cnt_q, out_cnt_d;
  logic [3:0]            inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [RD_LATENCY:0]   rd_pipe_shift;
  logic                  err_q, err_d;

  logic [1:0]  cfg_mode_q, cfg_mode_ext_q, cfg_block_type_q;
  logic [8:0]  cfg_big_values_q;
  logic        cfg_wsf_q, cfg_mixed_q, gr_q;
  logic [15:0] st_ch1_q, st_ch2_q, wr_ch1_q, wr_ch2_q;
  logic [9:0]  st_is_pos_q;
  logic        st_din_v_q, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic start_acc;
  logic accept;
  logic rd_fire;
  logic pipe_emit;

  assign start_acc = (state_q == StIdle) && start;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

  // Gated on the registered inflight count, so it can never exceed MAX_INFLIGHT.
  assign rd_fire = (state_q == StRun) && (issue_cnt_q < SamplesC) && (inflight_q < MaxInflC);
  assign rd_en   = rd_fire;
  assign rd_addr = rd_fire ? issue_cnt_q[ADDR_W-1:0] : '0;

  // A result is only legal while a pair is actually outstanding.
  assign accept = st_dout_v && busy && (inflight_q != 4'd0);

  assign rd_pipe_shift = {rd_pipe_q, rd_fire};
  assign rd_pipe_d     = rd_pipe_shift[RD_LATENCY-1:0];
  assign pipe_emit     = rd_pipe_q[RD_LATENCY-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (issue_cnt_q == SamplesC) state_d = StDrain;
      StDrain: if (out_cnt_q == SamplesC) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = inflight_q;
    if (start_acc) begin
      issue_cnt_d = '0;
      out_cnt_d   = '0;
      inflight_d  = '0;
    end else begin
      if (rd_fire) issue_cnt_d = issue_cnt_q + CntW'(1);
      if (accept)  out_cnt_d   = out_cnt_q + CntW'(1);
      if (rd_fire && !accept)      inflight_d = inflight_q + 4'd1;
      else if (!rd_fire && accept) inflight_d = inflight_q - 4'd1;
    end
    err_d = err_q | (st_dout_v && !accept);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= StIdle;
      issue_cnt_q      <= '0;
      out_cnt_q        <= '0;
      inflight_q       <= '0;
      rd_pipe_q        <= '0;
      err_q            <= 1'b0;
      cfg_mode_q       <= '0;
      cfg_mode_ext_q   <= '0;
      cfg_big_values_q <= '0;
      cfg_wsf_q        <= 1'b0;
      cfg_block_type_q <= '0;
      cfg_mixed_q      <= 1'b0;
      gr_q             <= 1'b0;
      st_ch1_q         <= '0;
      st_ch2_q         <= '0;
      st_is_pos_q      <= '0;
      st_din_v_q       <= 1'b0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_ch1_q         <= '0;
      wr_ch2_q         <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      rd_pipe_q   <= rd_pipe_d;
      err_q       <= err_d;
      if (start_acc) begin
        cfg_mode_q       <= cfg_mode;
        cfg_mode_ext_q   <= cfg_mode_ext;
        cfg_big_values_q <= cfg_big_values;
        cfg_wsf_q        <= cfg_wsf;
        cfg_block_type_q <= cfg_block_type;
        cfg_mixed_q      <= cfg_mixed;
        gr_q             <= gr_in;
      end
      // Buffer data is valid in the cycle the delayed strobe emerges; capture it here.
      st_din_v_q <= pipe_emit;
      if (pipe_emit) begin
        st_ch1_q    <= rd_ch1;
        st_ch2_q    <= rd_ch2;
        st_is_pos_q <= rd_is_pos;
      end
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= out_cnt_q[ADDR_W-1:0];
        wr_ch1_q  <= st_ch1_out;
        wr_ch2_q  <= st_ch2_out;
      end
    end
  end

  assign st_cfg_mode       = cfg_mode_q;
  assign st_cfg_mode_ext   = cfg_mode_ext_q;
  assign st_cfg_big_values = cfg_big_values_q;
  assign st_cfg_wsf        = cfg_wsf_q;
  assign st_cfg_block_type = cfg_block_type_q;
  assign st_cfg_mixed      = cfg_mixed_q;
  assign st_gr             = gr_q;
  assign st_ch1            = st_ch1_q;
  assign st_ch2            = st_ch2_q;
  assign st_is_pos         = st_is_pos_q;
  assign st_din_v          = st_din_v_q;
  assign wr_en             = wr_en_q;
  assign wr_addr           = wr_addr_q;
  assign wr_ch1            = wr_ch1_q;
  assign wr_ch2            = wr_ch2_q;
  assign err               = err_q;

endmodule

// File: tb/tb_stereo_sequencer.sv
// Self-checking bench for stereo_sequencer: buffer model with 2-cycle read
// latency, stereo model with configurable latency, and a write-back scoreboard.
module tb_stereo_sequencer;

  logic        clk;
  logic        rst;
  logic        start, gr_in;
  logic [1:0]  cfg_mode, cfg_mode_ext, cfg_block_type;
  logic [8:0]  cfg_big_values;
  logic        cfg_wsf, cfg_mixed;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_ch1, rd_ch2;
  logic [9:0]  rd_is_pos;
  logic [1:0]  st_cfg_mode, st_cfg_mode_ext, st_cfg_block_type;
  logic [8:0]  st_cfg_big_values;
  logic        st_cfg_wsf, st_cfg_mixed, st_gr;
  logic [15:0] st_ch1, st_ch2;
  logic [9:0]  st_is_pos;
  logic        st_din_v, st_dout_v;
  logic [15:0] st_ch1_out, st_ch2_out;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_ch1, wr_ch2;
  logic        busy, done, err;

  stereo_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .gr_in             (gr_in),
    .cfg_mode          (cfg_mode),
    .cfg_mode_ext      (cfg_mode_ext),
    .cfg_big_values    (cfg_big_values),
    .cfg_wsf           (cfg_wsf),
    .cfg_block_type    (cfg_block_type),
    .cfg_mixed         (cfg_mixed),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_ch1            (rd_ch1),
    .rd_ch2            (rd_ch2),
    .rd_is_pos         (rd_is_pos),
    .st_cfg_mode       (st_cfg_mode),
    .st_cfg_mode_ext   (st_cfg_mode_ext),
    .st_cfg_big_values (st_cfg_big_values),
    .st_cfg_wsf        (st_cfg_wsf),
    .st_cfg_block_type (st_cfg_block_type),
    .st_cfg_mixed      (st_cfg_mixed),
    .st_gr             (st_gr),
    .st_ch1            (st_ch1),
    .st_ch2            (st_ch2),
    .st_is_pos         (st_is_pos),
    .st_din_v          (st_din_v),
    .st_dout_v         (st_dout_v),
    .st_ch1_out        (st_ch1_out),
    .st_ch2_out        (st_ch2_out),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_ch1            (wr_ch1),
    .wr_ch2            (wr_ch2),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct { int rel; logic [15:0] a; logic [15:0] b; } sq_t;
  typedef struct { int addr; logic [15:0] a; logic [15:0] b; } exp_t;

  sq_t  sq[$];
  exp_t eq[$];

  int n_err, n_checks;
  int cyc, lat;
  int n_rd, n_din, n_dout, n_wr, done_cnt, inflight_m, max_infl;
  int p1, p2;
  logic [2:0]  rd_hist;
  logic [15:0] salt;
  logic [17:0] exp_cfg;

  function automatic logic [15:0] f1(input int i);
    return 16'(i) ^ salt;
  endfunction

  function automatic logic [9:0] fpos(input int i);
    return 10'(i) ^ salt[9:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] cur_cfg();
    return {st_gr, st_cfg_mode, st_cfg_mode_ext, st_cfg_big_values, st_cfg_wsf,
            st_cfg_block_type, st_cfg_mixed};
  endfunction

  task automatic clear_models();
    sq.delete();
    eq.delete();
    n_rd = 0; n_din = 0; n_dout = 0; n_wr = 0; done_cnt = 0;
    inflight_m = 0; max_infl = 0; p1 = 0; p2 = 0; rd_hist = 3'b000;
  endtask

  // One clock cycle: check the DUT outputs of the new cycle, then drive the
  // buffer and stereo models for it.
  task automatic step();
    sq_t  s;
    exp_t e;
    logic exp_rd;
    @(posedge clk);
    #1;
    cyc++;
    chk("din_lag", 128'(st_din_v), 128'(rd_hist[2]));
    exp_rd = busy && (n_rd < 576) && (inflight_m < 4);
    chk("rd_en", 128'(rd_en), 128'(exp_rd));
    if (rd_en) chk("rd_addr", 128'(rd_addr), 128'(n_rd));
    if (st_din_v) begin
      chk("st_pair", 128'({st_ch1, st_ch2, st_is_pos}),
          128'({f1(n_din), ~f1(n_din), fpos(n_din)}));
      s.rel = cyc + lat;
      s.a   = st_ch1;
      s.b   = st_ch2;
      sq.push_back(s);
      n_din++;
    end
    if (wr_en) begin
      if (eq.size() == 0) begin
        chk("wr_spurious", 128'(wr_en), 128'(0));
      end else begin
        e = eq.pop_front();
        chk("wr", 128'({wr_addr, wr_ch1, wr_ch2}), 128'({10'(e.addr), e.a, e.b}));
      end
      n_wr++;
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", 128'(busy), 128'(0));
    end
    rd_ch1    = f1(p2);
    rd_ch2    = ~f1(p2);
    rd_is_pos = fpos(p2);
    p2 = p1;
    p1 = int'(rd_addr);
    st_dout_v = 1'b0;
    if (sq.size() > 0 && sq[0].rel <= cyc) begin
      s = sq.pop_front();
      st_dout_v  = 1'b1;
      st_ch1_out = s.a;
      st_ch2_out = s.b;
      e.addr = n_dout;
      e.a    = f1(n_dout);
      e.b    = ~f1(n_dout);
      eq.push_back(e);
      n_dout++;
      inflight_m--;
    end
    if (rd_en) begin
      n_rd++;
      inflight_m++;
    end
    if (inflight_m > max_infl) max_infl = inflight_m;
    rd_hist = {rd_hist[1:0], rd_en};
  endtask

  task automatic set_cfg(input logic [17:0] c);
    {gr_in, cfg_mode, cfg_mode_ext, cfg_big_values, cfg_wsf, cfg_block_type, cfg_mixed} = c;
  endtask

  task automatic do_start(input logic [17:0] c);
    clear_models();
    set_cfg(c);
    exp_cfg = c;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_latch", 128'(cur_cfg()), 128'(exp_cfg));
    chk("busy_start", 128'(busy), 128'(1));
  endtask

  task automatic finish_granule(input string tag);
    for (int i = 0; i < 8000 && done_cnt == 0; i++) step();
    repeat (3) step();
    chk({tag, "_done_once"}, 128'(done_cnt), 128'(1));
    chk({tag, "_wr_count"}, 128'(n_wr), 128'(576));
    chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    chk({tag, "_err_clean"}, 128'(err), 128'(0));
    chk({tag, "_cfg_hold"}, 128'(cur_cfg()), 128'(exp_cfg));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 128'({rd_en, rd_addr, st_din_v, st_ch1, st_ch2, st_is_pos,
                              wr_en, wr_addr, wr_ch1, wr_ch2}), 128'(0));
    chk({tag, "_ctrl"}, 128'({cur_cfg(), busy, done, err}), 128'(0));
  endtask

  initial begin
    n_err = 0; n_checks = 0; cyc = 0; lat = 3; salt = 16'h0000;
    clear_models();
    rst = 1'b0; start = 1'b0; st_dout_v = 1'b0;
    st_ch1_out = '0; st_ch2_out = '0; rd_ch1 = '0; rd_ch2 = '0; rd_is_pos = '0;
    set_cfg(18'h0);
    exp_cfg = 18'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    repeat (2) step();

    // Identity stereo, 3-cycle latency, ch1[i]=i, ch2[i]=~i.
    lat = 3; salt = 16'h0000;
    do_start({1'b1, 2'd1, 2'd2, 9'd300, 1'b1, 2'd2, 1'b1});
    finish_granule("t1");
    chk("t1_max_infl", 128'(max_infl), 128'(4));

    // Stereo holds each result 20 cycles: credit limit governs issue.
    lat = 20; salt = 16'h5a5a;
    do_start({1'b0, 2'd3, 2'd1, 9'd17, 1'b0, 2'd1, 1'b0});
    repeat (10) step();
    chk("t2_stall_issues", 128'(n_rd), 128'(4));
    finish_granule("t2");
    chk("t2_max_infl", 128'(max_infl), 128'(4));

    // Second start during RUN is ignored.
    lat = 3; salt = 16'h1234;
    do_start({1'b1, 2'd2, 2'd0, 9'd450, 1'b1, 2'd0, 1'b0});
    for (int i = 0; i < 2000 && n_rd < 100; i++) step();
    set_cfg({1'b0, 2'd1, 2'd3, 9'd5, 1'b0, 2'd3, 1'b1});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_cfg_ignored", 128'(cur_cfg()), 128'(exp_cfg));
    chk("t4_still_busy", 128'(busy), 128'(1));
    finish_granule("t4");

    // Reset mid-granule, then a clean restart.
    lat = 3; salt = 16'h0f0f;
    do_start({1'b0, 2'd1, 2'd1, 9'd100, 1'b0, 2'd2, 1'b0});
    for (int i = 0; i < 3000 && n_rd < 300; i++) step();
    chk("t5_reached_300", 128'(n_rd), 128'(300));
    rst = 1'b0;
    start = 1'b0;
    st_dout_v = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk_zero("t5_rst");
    clear_models();
    rst = 1'b1;
    repeat (3) step();
    do_start({1'b1, 2'd0, 2'd3, 9'd288, 1'b1, 2'd1, 1'b1});
    finish_granule("t5");

    // Spurious stereo result while IDLE.
    st_ch1_out = 16'hdead;
    st_ch2_out = 16'hbeef;
    st_dout_v  = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    st_dout_v = 1'b0;
    chk("t6_err_set", 128'(err), 128'(1));
    chk("t6_no_wr", 128'(wr_en), 128'(0));
    repeat (5) step();
    chk("t6_err_sticky", 128'(err), 128'(1));
    chk("t6_idle", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
